// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: controller states
// and the 2-bit verdict code passed between the bit cell and the top level.
package serial_magnitude_comparator_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPARE = 1'b1;

  localparam logic [1:0] VERDICT_EQ = 2'b00;
  localparam logic [1:0] VERDICT_GT = 2'b01;
  localparam logic [1:0] VERDICT_LT = 2'b10;

  // Fold the bit cell's greater/less flags into the verdict code.
  function automatic logic [1:0] verdict_of(input logic greater, input logic less);
    if (greater)   return VERDICT_GT;
    else if (less) return VERDICT_LT;
    else           return VERDICT_EQ;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_bit_cell.sv
// One-bit combinational compare cell. The invert input swaps the meaning of a
// differing bit pair, which is how a two's-complement sign bit is handled.
module comparator_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic greater,
  output logic less
);

  logic a_hi;
  logic b_hi;

  assign a_hi = a_bit & ~b_bit;
  assign b_hi = ~a_bit & b_bit;

  assign greater = invert ? b_hi : a_hi;
  assign less    = invert ? a_hi : b_hi;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: operands are captured on start, then
// compared MSB first, one bit per clock, until the first difference (when
// EARLY_EXIT=1) or the LSB. The verdict is registered and held between runs.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         gt,
  output logic                         eq,
  output logic                         lt,
  output logic [$clog2(WIDTH+1)-1:0]   nbits
);

  localparam int NB = $clog2(WIDTH+1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [1:0]       pending;
  logic             first_bit;
  logic             last_bit;
  logic             invert;
  logic             greater;
  logic             less;
  logic [1:0]       bit_verdict;
  logic [1:0]       final_verdict;
  logic             finish;

  assign busy      = (state == ST_COMPARE);
  assign first_bit = (nbits == '0);
  assign last_bit  = (nbits == NB'(WIDTH-1));
  // Only the sign bit (the first one examined) has inverted polarity.
  assign invert    = (SIGNED != 0) && first_bit;

  comparator_bit_cell u_bit_cell (
    .a_bit   (shift_a[WIDTH-1]),
    .b_bit   (shift_b[WIDTH-1]),
    .invert  (invert),
    .greater (greater),
    .less    (less)
  );

  // Resolve this cycle's bit against any earlier difference and decide
  // whether this is the terminating edge.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bit_verdict   = verdict_of(greater, less);
    final_verdict = pending;
    finish        = last_bit;
    if (pending == VERDICT_EQ) final_verdict = bit_verdict;
    if ((EARLY_EXIT != 0) && (bit_verdict != VERDICT_EQ)) finish = 1'b1;
  end

  // Controller: sequencing, bit count, first-difference latch and verdict.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      nbits   <= '0;
      pending <= VERDICT_EQ;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_COMPARE;
            nbits   <= '0;
            pending <= VERDICT_EQ;
          end
        end
        default: begin
          nbits   <= nbits + NB'(1);
          pending <= final_verdict;
          if (finish) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            gt    <= (final_verdict == VERDICT_GT);
            eq    <= (final_verdict == VERDICT_EQ);
            lt    <= (final_verdict == VERDICT_LT);
          end
        end
      endcase
    end
  end

  // Operand shift registers: load on accepted start, shift MSB-first while comparing.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath, no reset; contents are only read while state is COMPARE.
    if ((state == ST_IDLE) && start) begin
      shift_a <= a;
      shift_b <= b;
    end else if (state == ST_COMPARE) begin
      shift_a <= {shift_a[WIDTH-2:0], 1'b0};
      shift_b <= {shift_b[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: three comparator instances (unsigned/early-exit,
// signed/early-exit, unsigned/full-scan) share clock, reset and operands and
// are checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [2:0]   start_v;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   gt_v;
  logic [2:0]   eq_v;
  logic [2:0]   lt_v;
  logic [3:0]   nbits_v [3];

  int passed;
  int total;
  logic [2:0] prev [3];

  serial_magnitude_comparator #(.WIDTH(W), .SIGNED(0), .EARLY_EXIT(1)) dut_u (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_in), .b(b_in),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]),
    .nbits(nbits_v[0]));

  serial_magnitude_comparator #(.WIDTH(W), .SIGNED(1), .EARLY_EXIT(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_in), .b(b_in),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]),
    .nbits(nbits_v[1]));

  serial_magnitude_comparator #(.WIDTH(W), .SIGNED(0), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .reset(reset), .start(start_v[2]), .a(a_in), .b(b_in),
    .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]),
    .nbits(nbits_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] verdict(input int i);
    return {gt_v[i], eq_v[i], lt_v[i]};
  endfunction

  // Reference: numeric comparison plus count of positions up to first difference.
  function automatic void model(input int inst, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [2:0] v, output int n);
    bit sg;
    bit early;
    int x;
    int y;
    sg    = (inst == 1);
    early = (inst != 2);
    x = sg ? int'($signed(av)) : int'({24'd0, av});
    y = sg ? int'($signed(bv)) : int'({24'd0, bv});
    if (x > y)       v = 3'b100;
    else if (x == y) v = 3'b010;
    else             v = 3'b001;
    n = W;
    if (early && (av != bv)) begin
      for (int h = W - 1; h >= 0; h--) begin
        if (av[h] != bv[h]) begin
          n = W - h;
          break;
        end
      end
    end
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    start_v = 3'b111;
    a_in    = 8'h12;
    b_in    = 8'h34;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy_v[i], done_v[i], verdict(i), nbits_v[i]} !== 9'd0) begin
        $display("FAIL reset inst%0d busy=%b done=%b gt/eq/lt=%b nbits=%0d expected all 0",
                 i, busy_v[i], done_v[i], verdict(i), nbits_v[i]);
      end else passed++;
      prev[i] = 3'b000;
    end
    reset   = 1'b0;
    start_v = 3'b000;
    step();
    total++;
    if (busy_v !== 3'b000) $display("FAIL reset_start busy=%b expected 000", busy_v);
    else passed++;
  endtask

  // One comparison on all instances; optionally pulse start with junk operands mid-run.
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch);
    logic [2:0] ev [3];
    int en [3];
    int pulses [3];
    int lat [3];
    for (int i = 0; i < 3; i++) begin
      model(i, av, bv, ev[i], en[i]);
      pulses[i] = 0;
      lat[i]    = -1;
    end
    a_in    = av;
    b_in    = bv;
    start_v = 3'b111;
    step();
    start_v = 3'b000;
    total++;
    if (busy_v !== 3'b111) $display("FAIL busy_after_start a=%h b=%h busy=%b expected 111", av, bv, busy_v);
    else passed++;
    for (int c = 1; c <= W + 2; c++) begin
      if (glitch && c == 2) begin
        a_in    = 8'hFF;
        b_in    = 8'h00;
        start_v = 3'b111;
      end
      step();
      if (glitch && c == 2) start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          pulses[i]++;
          if (lat[i] < 0) lat[i] = c;
        end else if (lat[i] < 0 && c < en[i]) begin
          total++;
          if (verdict(i) !== prev[i])
            $display("FAIL held inst%0d a=%h b=%h cycle %0d gt/eq/lt=%b expected %b",
                     i, av, bv, c, verdict(i), prev[i]);
          else passed++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pulses[i] !== 1 || lat[i] !== en[i])
        $display("FAIL latency inst%0d a=%h b=%h done pulses=%0d at %0d expected 1 at %0d",
                 i, av, bv, pulses[i], lat[i], en[i]);
      else passed++;
      total++;
      if (verdict(i) !== ev[i])
        $display("FAIL verdict inst%0d a=%h b=%h gt/eq/lt=%b expected %b", i, av, bv, verdict(i), ev[i]);
      else passed++;
      total++;
      if (int'(nbits_v[i]) !== en[i])
        $display("FAIL nbits inst%0d a=%h b=%h nbits=%0d expected %0d", i, av, bv, nbits_v[i], en[i]);
      else passed++;
      prev[i] = ev[i];
    end
  endtask

  task automatic test_directed();
    run_cmp(8'h5A, 8'h5A, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0);
    run_cmp(8'hFF, 8'hFE, 1'b0);
    run_cmp(8'h83, 8'h03, 1'b0);
    run_cmp(8'h00, 8'hFF, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_cmp(8'h10, 8'h20, 1'b1);
  endtask

  task automatic test_abort();
    int seen;
    a_in    = 8'h10;
    b_in    = 8'h20;
    start_v = 3'b111;
    step();
    start_v = 3'b000;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy_v[i], done_v[i], verdict(i), nbits_v[i]} !== 9'd0)
        $display("FAIL abort inst%0d busy=%b done=%b gt/eq/lt=%b nbits=%0d expected all 0",
                 i, busy_v[i], done_v[i], verdict(i), nbits_v[i]);
      else passed++;
      prev[i] = 3'b000;
    end
    seen = 0;
    for (int c = 0; c < W + 2; c++) begin
      step();
      if (done_v !== 3'b000 || busy_v !== 3'b000) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL abort_quiet activity cycles=%0d expected 0", seen);
    else passed++;
  endtask

  // Start held high across the done cycle; the second run must begin there.
  task automatic test_back_to_back();
    logic [2:0] ev1 [3];
    int k1 [3];
    logic [2:0] ev2;
    int k2;
    int phase [3];
    int lat1 [3];
    int lat2 [3];
    for (int i = 0; i < 3; i++) begin
      model(i, 8'h80, 8'h7F, ev1[i], k1[i]);
      phase[i] = 0;
      lat1[i]  = -1;
      lat2[i]  = -1;
    end
    model(0, 8'h01, 8'h01, ev2, k2);
    a_in    = 8'h80;
    b_in    = 8'h7F;
    start_v = 3'b111;
    step();
    a_in = 8'h01;
    b_in = 8'h01;
    for (int c = 1; c <= 2 * W + 4; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        case (phase[i])
          0: if (done_v[i]) begin
               lat1[i]  = c;
               phase[i] = 1;
               total++;
               if (verdict(i) !== ev1[i])
                 $display("FAIL b2b_first inst%0d gt/eq/lt=%b expected %b", i, verdict(i), ev1[i]);
               else passed++;
             end
          1: begin
               start_v[i] = 1'b0;
               phase[i]   = 2;
               total++;
               if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0)
                 $display("FAIL b2b_accept inst%0d busy=%b done=%b expected busy=1 done=0",
                          i, busy_v[i], done_v[i]);
               else passed++;
             end
          default: if (lat2[i] < 0) begin
               if (done_v[i]) lat2[i] = c;
               else begin
                 total++;
                 if (verdict(i) !== ev1[i])
                   $display("FAIL b2b_held inst%0d cycle %0d gt/eq/lt=%b expected %b",
                            i, c, verdict(i), ev1[i]);
                 else passed++;
               end
             end
        endcase
      end
    end
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (lat1[i] !== k1[i] || lat2[i] !== k1[i] + 1 + k2)
        $display("FAIL b2b_latency inst%0d first=%0d second=%0d expected %0d and %0d",
                 i, lat1[i], lat2[i], k1[i], k1[i] + 1 + k2);
      else passed++;
      total++;
      if (verdict(i) !== ev2 || int'(nbits_v[i]) !== k2)
        $display("FAIL b2b_second inst%0d gt/eq/lt=%b nbits=%0d expected %b nbits=%0d",
                 i, verdict(i), nbits_v[i], ev2, k2);
      else passed++;
      prev[i] = ev2;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int n = 0; n < 40; n++) begin
      av = W'($urandom);
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ W'(1 << $urandom_range(0, W - 1));
        default: bv = W'($urandom);
      endcase
      run_cmp(av, bv, 1'b0);
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    start_v = 3'b000;
    a_in    = '0;
    b_in    = '0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
